// File: rtl/risc_v_mike_pkg.sv
// Shared core definitions: unified memory map and the memory-port arbiter types.
package risc_v_mike_pkg;

  localparam logic [31:0] MEM_MAP_TEXT_LOWER_LIMIT  = 32'h0040_0000;
  localparam logic [31:0] MEM_MAP_TEXT_UPPER_LIMIT  = 32'h0040_1000;
  localparam logic [31:0] MEM_MAP_DATA_LOWER_LIMIT  = 32'h1001_0000;
  localparam logic [31:0] MEM_MAP_DATA_UPPER_LIMIT  = 32'h1001_03ff;
  localparam logic [31:0] MEM_MAP_MMIO_LOWER_LIMIT  = 32'h1001_0024;
  localparam logic [31:0] MEM_MAP_MMIO_UPPER_LIMIT  = 32'h1001_0040;
  localparam logic [31:0] MEM_MAP_STACK_UPPER_LIMIT = 32'h7fff_effc;
  localparam logic [31:0] DATA_MAPPING_STACK_DIV    = 32'h0000_0400;
  // Stack grows down from the upper limit; the lower limit itself is excluded.
  localparam logic [31:0] MEM_MAP_STACK_LOWER_LIMIT =
    MEM_MAP_STACK_UPPER_LIMIT - DATA_MAPPING_STACK_DIV;

  typedef enum logic [1:0] {
    REG_TEXT  = 2'd0,
    REG_DATA  = 2'd1,
    REG_STACK = 2'd2,
    REG_MMIO  = 2'd3
  } t_mem_region;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } t_arb_state;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } t_owner;

endpackage

// File: rtl/mem_region_decoder.sv
// Combinational address decode: region, region-relative offset and access fault.
module mem_region_decoder
  import risc_v_mike_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        is_fetch,
  input  logic        we,
  output t_mem_region region,
  output logic [31:0] offset,
  output logic        fault
);

  logic mapped;

  always_comb begin
    region = REG_TEXT;
    offset = '0;
    mapped = 1'b1;
    // MMIO is tested first because it sits inside the data window.
    if (addr >= MEM_MAP_MMIO_LOWER_LIMIT && addr < MEM_MAP_MMIO_UPPER_LIMIT) begin
      region = REG_MMIO;
      offset = addr - MEM_MAP_MMIO_LOWER_LIMIT;
    end else if (addr > MEM_MAP_STACK_LOWER_LIMIT && addr <= MEM_MAP_STACK_UPPER_LIMIT) begin
      region = REG_STACK;
      offset = addr - (MEM_MAP_STACK_LOWER_LIMIT + 32'd1);
    end else if (addr >= MEM_MAP_DATA_LOWER_LIMIT && addr <= MEM_MAP_DATA_UPPER_LIMIT) begin
      region = REG_DATA;
      offset = addr - MEM_MAP_DATA_LOWER_LIMIT;
    end else if (addr >= MEM_MAP_TEXT_LOWER_LIMIT && addr < MEM_MAP_TEXT_UPPER_LIMIT) begin
      region = REG_TEXT;
      offset = addr - MEM_MAP_TEXT_LOWER_LIMIT;
    end else begin
      mapped = 1'b0;
    end
    fault = !mapped
         || (is_fetch && region != REG_TEXT)
         || (!is_fetch && we && region == REG_TEXT);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto the single memory port and sequences fixed-latency reads.
module mem_port_arbiter
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned MEM_LAT       = 1,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_fault,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_fault,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [1:0]  mem_sel,
  output logic [31:0] mem_offset,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned          STREAK_W   = $clog2(MAX_LS_STREAK + 1);
  localparam logic [1:0]           LAT        = 2'(MEM_LAT);
  localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  t_arb_state          state_q, state_d;
  t_owner              owner_q, owner_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic        idle, pick_ls, pick_if, win_we, win_fault, ret;
  logic [31:0] win_addr, dec_offset;
  t_mem_region dec_region;

  always_comb begin
    idle     = (state_q == ARB_IDLE);
    pick_ls  = idle && ls_req && !(if_req && streak_q == STREAK_MAX);
    pick_if  = idle && if_req && !pick_ls;
    win_addr = pick_ls ? ls_addr : if_addr;
    win_we   = pick_ls && ls_we;
  end

  mem_region_decoder u_decoder (
    .addr     (win_addr),
    .is_fetch (!pick_ls),
    .we       (win_we),
    .region   (dec_region),
    .offset   (dec_offset),
    .fault    (win_fault)
  );

  always_comb begin
    if_gnt     = pick_if;
    ls_gnt     = pick_ls;
    if_fault   = pick_if && win_fault;
    ls_fault   = pick_ls && win_fault;
    mem_req    = (pick_if || pick_ls) && !win_fault;
    mem_we     = mem_req && win_we;
    mem_be     = !mem_req ? 4'h0 : (pick_ls ? ls_be : 4'hf);
    mem_sel    = mem_req ? dec_region : REG_TEXT;
    mem_offset = mem_req ? dec_offset : '0;
    mem_wdata  = mem_we ? ls_wdata : '0;
    ret        = (state_q == ARB_WAIT) && (cnt_q == 2'd1);
    if_rvalid  = ret && (owner_q == OWN_IF);
    ls_rvalid  = ret && (owner_q == OWN_LS);
    if_rdata   = if_rvalid ? mem_rdata : '0;
    ls_rdata   = ls_rvalid ? mem_rdata : '0;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req && !mem_we) begin
          state_d = ARB_WAIT;
          owner_d = pick_ls ? OWN_LS : OWN_IF;
          cnt_d   = LAT;
        end
      end
      ARB_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // A fetch can only be starved while it is actually waiting.
    if (!if_req || pick_if) streak_d = '0;
    else if (pick_ls)       streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified memory between the instruction-fetch requester and the load/store requester of the RISC-V core. Decodes each granted address into the text, data, stack or MMIO region using the package memory map, and returns a region-relative offset. Sequences fixed-latency reads and flags unmapped or illegal accesses. Sits between the fetch/LSU stages and the memory macro and MMIO wrapper.

## Interface
- MEM_LAT, 1: memory read latency in cycles, legal range 1..3.
- MAX_LS_STREAK, 4: consecutive load/store grants allowed while a fetch is pending.
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req / if_addr  in  1 / 32  fetch request and byte address.
- if_gnt / if_fault / if_rvalid / if_rdata  out  1/1/1/32  fetch grant, fault, read return.
- ls_req / ls_we / ls_be / ls_addr / ls_wdata  in  1/1/4/32/32  load/store request.
- ls_gnt / ls_fault / ls_rvalid / ls_rdata  out  1/1/1/32  load/store grant, fault, read return.
- mem_req / mem_we / mem_be  out  1/1/4  memory strobe, write enable, byte enables.
- mem_sel  out  2  region: 0 text, 1 data, 2 stack, 3 MMIO.
- mem_offset / mem_wdata  out  32/32  region-relative byte offset, write data.
- mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_req.

## Operation
- FSM states: IDLE, WAIT. Grants are issued only in IDLE.
- Region decode, priority order: MMIO [MMIO_LOWER, MEM_MAP_MMIO_UPPER_LIMIT); stack (MEM_MAP_STACK_LOWER_LIMIT, STACK_UPPER]; data [DATA_LOWER, MEM_MAP_DATA_UPPER_LIMIT]; text [TEXT_LOWER, MEM_MAP_TEXT_UPPER_LIMIT). MMIO wins where it overlaps data.
- mem_offset = addr − region lower bound. For stack, the lower bound is MEM_MAP_STACK_LOWER_LIMIT+1. 32-bit wrap-free.
- Fetch outside text faults. A load/store write to text faults. A load/store read of text is allowed. Unmapped addresses fault.
- Arbitration:
  - Load/store has priority.
  - streak counts consecutive ls grants while if_req=1.
  - If streak==MAX_LS_STREAK and if_req=1, the fetch is granted.
  - streak clears on any fetch grant, and on any cycle with if_req=0.
- Fault access: gnt and fault pulse together for 1 cycle. No mem_req and no rvalid. FSM stays IDLE.
- Write: gnt, mem_req, mem_we pulse in the same cycle. FSM stays IDLE. No rvalid.
- Read: gnt and mem_req pulse; owner is registered; FSM goes to WAIT with counter=MEM_LAT.
- rvalid and rdata go to the owner only. rdata = mem_rdata passthrough, gated to 0 when rvalid=0.
- Requesters hold req/addr/data stable until gnt. A change before gnt is illegal.

## Timing
- Grant at cycle T.
- Read return: mem_rdata sampled and rvalid asserted at T+MEM_LAT. FSM returns to IDLE at the end of that cycle. Next grant earliest at T+MEM_LAT+1.
- Read throughput: 1 per MEM_LAT+1 cycles. Write and fault throughput: 1 per cycle.
- mem_req, mem_sel, mem_offset, gnt and fault are combinational from IDLE state plus requests. No request-to-grant latency.
- Reset values: all outputs 0; state IDLE, streak 0, counter 0.
- rst_n asserted mid-read: the outstanding read is dropped and no rvalid is issued after release.
- Simultaneous if_req and ls_req in IDLE with streak<MAX_LS_STREAK: ls granted.

## Structure
- Add to risc_v_mike_pkg:
  - t_mem_region enum (REG_TEXT, REG_DATA, REG_STACK, REG_MMIO).
  - t_arb_state enum (ARB_IDLE, ARB_WAIT).
  - An owner type.
- Existing MEM_MAP_* limits are reused. No new address constants.
- Sub-module mem_region_decoder, purely combinational (addr, is_fetch, we → region, offset, fault), instantiated once on the muxed winner address.

## Test plan
- ls read 0x10010004, MEM_LAT=2:
  - Cycle T: ls_gnt=1, mem_sel=1, mem_offset=0x4.
  - Cycle T+2: ls_rvalid=1, ls_rdata=mem_rdata.
- if_req and ls_req held continuously, MAX_LS_STREAK=4: 4 ls grants, then 1 if grant, repeating. No fetch waits more than 4 grants.
- ls write to 0x00400010: ls_gnt=1 and ls_fault=1 in one cycle, mem_req=0.
- Fetch 0x10010000: if_fault=1, no if_rvalid.
- ls read 0x10010024 (MMIO overlap): mem_sel=3, mem_offset=0.
- ls read of 0x7fffeffc: mem_sel=2, mem_offset=DATA_MAPPING_STACK_DIV−1.
- rst_n low at T+1 of a MEM_LAT=3 read: no rvalid. After release, all outputs are 0 and a new request is granted.
